// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types for the operand sweep generator.
//   sweep_mode_t  - pattern select, latched when a sweep starts
//   sweep_state_t - top-level sequencer states
package sweep_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_WALK = 2'd3
  } sweep_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: counts enabled cycles of the current sweep value.
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, clears the count
//   clear  - synchronous clear (held while the sweep is not running)
//   en     - count this cycle (the cycle just ending carried a live value)
//   expire - high when count == DWELL-1 and en; the count wraps to 0 at that edge
module sweep_dwell_timer #(
  parameter int unsigned DWELL = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LastCount = CW'(DWELL - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = en && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (clear || expire) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/operand_sweep_gen.sv
// operand_sweep_gen: drives an operand through an up / down / Gray / walking-one
// sweep, holding each value for DWELL live cycles, then pulses done.
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (aborts a sweep, no done pulse)
//   start - begin a sweep (sampled in IDLE only)
//   pause - freeze the sweep (sampled in RUN only)
//   mode  - pattern select, latched on the start edge
//   a_out - operand for the downstream stage (registered)
//   valid - a_out is a live sweep value (registered)
//   busy  - sweep in progress (registered)
//   done  - one-cycle pulse after the final value (registered)
//
// pause is sampled at each edge: a cycle is live (valid=1) when the edge that
// began it was in RUN with pause low. The dwell timer counts live cycles, so
// each value is shown for exactly DWELL valid cycles regardless of pausing.
module operand_sweep_gen
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] a_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  sweep_state_t     state_q, state_d;
  sweep_mode_t      mode_q, mode_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             expire;
  logic             last_step;
  sweep_mode_t      pat_mode;
  logic [WIDTH-1:0] pat_k;
  logic [WIDTH-1:0] pat_val;

  sweep_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != RUN),
    .en     (valid_q),
    .expire (expire)
  );

  // Walk covers WIDTH steps; the other patterns cover all 2^WIDTH codes.
  assign last_step = (mode_q == MODE_WALK) ? (k_q == WIDTH'(WIDTH - 1)) : (k_q == '1);

  // Pattern lookup: the seed (k=0, live mode input) in IDLE, else the next step.
  assign pat_mode = (state_q == IDLE) ? sweep_mode_t'(mode) : mode_q;
  assign pat_k    = (state_q == IDLE) ? '0 : k_q + WIDTH'(1);

  always_comb begin
    pat_val = '0;
    unique case (pat_mode)
      MODE_UP:   pat_val = pat_k;
      MODE_DOWN: pat_val = ~pat_k;
      MODE_GRAY: pat_val = pat_k ^ (pat_k >> 1);
      MODE_WALK: pat_val = WIDTH'(1) << pat_k;
      default:   pat_val = '0;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      k_q     <= '0;
      a_out_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      a_out_q <= a_out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (expire && last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    mode_d  = mode_q;
    k_d     = k_q;
    a_out_d = a_out_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = sweep_mode_t'(mode);
          k_d     = '0;
          a_out_d = pat_val;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (expire && last_step) begin
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b1;
          valid_d = !pause;
          if (expire) begin
            k_d     = k_q + WIDTH'(1);
            a_out_d = pat_val;
          end
        end
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

  assign a_out = a_out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_operand_sweep_gen.sv
// Directed bench for operand_sweep_gen: three instances (DWELL 10, 1, 2) share
// reset / mode / pause, each with its own start. Outputs are sampled 1 time
// unit after the rising edge; inputs change at the same point.
module tb_operand_sweep_gen;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  logic [1:0] mode = 2'd0;
  logic start10 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic [W-1:0] a10, a1, a2;
  logic v10, b10, d10, v1, b1, d1, v2, b2, d2;
  logic [W-1:0] y10;

  int errors = 0;
  int checks = 0;

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  // Downstream bitwise NOT stage.
  assign y10 = ~a10;

  operand_sweep_gen #(.WIDTH(W), .DWELL(10)) u10 (
    .clk(clk), .reset(reset), .start(start10), .pause(pause), .mode(mode),
    .a_out(a10), .valid(v10), .busy(b10), .done(d10)
  );
  operand_sweep_gen #(.WIDTH(W), .DWELL(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .pause(pause), .mode(mode),
    .a_out(a1), .valid(v1), .busy(b1), .done(d1)
  );
  operand_sweep_gen #(.WIDTH(W), .DWELL(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .pause(pause), .mode(mode),
    .a_out(a2), .valid(v2), .busy(b2), .done(d2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {valid, busy, done, a_out} per instance.
  task automatic chk10(input string tag, input logic v, input logic b, input logic d,
                       input logic [3:0] a);
    chk(tag, {25'd0, v10, b10, d10, a10}, {25'd0, v, b, d, a});
  endtask
  task automatic chk1(input string tag, input logic v, input logic b, input logic d,
                      input logic [3:0] a);
    chk(tag, {25'd0, v1, b1, d1, a1}, {25'd0, v, b, d, a});
  endtask
  task automatic chk2(input string tag, input logic v, input logic b, input logic d,
                      input logic [3:0] a);
    chk(tag, {25'd0, v2, b2, d2, a2}, {25'd0, v, b, d, a});
  endtask

  initial begin
    logic [3:0] prev;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk10("reset_u10", 1'b0, 1'b0, 1'b0, 4'd0);
    chk1("reset_u1", 1'b0, 1'b0, 1'b0, 4'd0);
    chk2("reset_u2", 1'b0, 1'b0, 1'b0, 4'd0);

    // 1. Up sweep, DWELL=10
    mode = 2'd0;
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    chk10("up_first", 1'b1, 1'b1, 1'b0, 4'd0);
    chk("up_y_first", 32'(y10), 32'd15);
    for (int i = 1; i < 160; i++) begin
      tick();
      chk10("up_step", 1'b1, 1'b1, 1'b0, 4'(i / 10));
      chk("up_y", 32'(y10), 32'(15 - i / 10));
    end
    tick();
    chk10("up_done", 1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    chk10("up_idle", 1'b0, 1'b0, 1'b0, 4'd15);
    tick();
    chk10("up_idle_hold", 1'b0, 1'b0, 1'b0, 4'd15);

    // 2. Gray sweep, DWELL=1
    mode = 2'd2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk1("gray_0", 1'b1, 1'b1, 1'b0, gray_tab[0]);
    prev = a1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk1("gray_step", 1'b1, 1'b1, 1'b0, gray_tab[i]);
      chk("gray_1bit", 32'($countones(a1 ^ prev)), 32'd1);
      prev = a1;
    end
    tick();
    chk1("gray_done", 1'b0, 1'b0, 1'b1, 4'd8);
    tick();
    chk1("gray_idle", 1'b0, 1'b0, 1'b0, 4'd8);

    // 3a. Walk, DWELL=2
    mode = 2'd3;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk2("walk_0", 1'b1, 1'b1, 1'b0, 4'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk2("walk_step", 1'b1, 1'b1, 1'b0, 4'(1 << (i / 2)));
    end
    tick();
    chk2("walk_done", 1'b0, 1'b0, 1'b1, 4'd8);
    tick();
    chk2("walk_idle", 1'b0, 1'b0, 1'b0, 4'd8);

    // 3b. Down, DWELL=2
    mode = 2'd1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk2("down_0", 1'b1, 1'b1, 1'b0, 4'd15);
    for (int i = 1; i < 32; i++) begin
      tick();
      chk2("down_step", 1'b1, 1'b1, 1'b0, 4'(15 - i / 2));
    end
    tick();
    chk2("down_done", 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    chk2("down_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // 4. Pause during value 5, DWELL=10
    mode = 2'd0;
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    chk10("pz_0", 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 53; i++) begin
      tick();
      chk10("pz_pre", 1'b1, 1'b1, 1'b0, 4'(i / 10));
    end
    pause = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      chk10("pz_held", 1'b0, 1'b1, 1'b0, 4'd5);
    end
    pause = 1'b0;
    for (int i = 54; i < 160; i++) begin
      tick();
      chk10("pz_post", 1'b1, 1'b1, 1'b0, 4'(i / 10));
    end
    tick();
    chk10("pz_done_167", 1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    chk10("pz_idle", 1'b0, 1'b0, 1'b0, 4'd15);

    // 5. Ignored start / mode mid-RUN, start held through DONE (DWELL=2, up)
    mode = 2'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk2("ign_0", 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i < 32; i++) begin
      if (i == 5) mode = 2'd1;
      start2 = (i == 10);
      tick();
      chk2("ign_step", 1'b1, 1'b1, 1'b0, 4'(i / 2));
    end
    start2 = 1'b1;
    mode = 2'd2;
    tick();
    chk2("ign_done", 1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    chk2("ign_start_in_done", 1'b0, 1'b0, 1'b0, 4'd15);
    tick();
    chk2("ign_restart_idle", 1'b1, 1'b1, 1'b0, 4'd0);
    start2 = 1'b0;
    tick();
    chk2("ign_restart_hold", 1'b1, 1'b1, 1'b0, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk2("ign_reset", 1'b0, 1'b0, 1'b0, 4'd0);

    // 6. Reset mid-sweep at a_out=9, then a clean sweep
    mode = 2'd0;
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    for (int i = 1; i <= 90; i++) tick();
    chk10("rst_at9", 1'b1, 1'b1, 1'b0, 4'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk10("rst_abort", 1'b0, 1'b0, 1'b0, 4'd0);
    for (int j = 0; j < 80; j++) begin
      tick();
      chk10("rst_no_done", 1'b0, 1'b0, 1'b0, 4'd0);
    end
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    chk10("rst_resweep_0", 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i < 160; i++) begin
      tick();
      chk10("rst_resweep", 1'b1, 1'b1, 1'b0, 4'(i / 10));
    end
    tick();
    chk10("rst_resweep_done", 1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    chk10("rst_resweep_idle", 1'b0, 1'b0, 1'b0, 4'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
